// File: rtl/fetch_unit_if.sv
// Bundles the fetch unit's instruction-memory and IF/ID pipeline signals.
// The master side is the fetch unit; the slave side is the memory/decode
// environment around it.
interface fetch_unit_if;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_valid_i;
    logic [31:0] imem_rdata_i;
    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        if_valid_o;
    logic [31:0] if_instr_o;
    logic [31:0] if_pc_o;
    logic [6:0]  if_opcode_o;

    modport master (
        output imem_req_o, imem_addr_o,
        output if_valid_o, if_instr_o, if_pc_o, if_opcode_o,
        input  imem_valid_i, imem_rdata_i,
        input  stall_i, redirect_i, redirect_pc_i
    );

    modport slave (
        input  imem_req_o, imem_addr_o,
        input  if_valid_o, if_instr_o, if_pc_o, if_opcode_o,
        output imem_valid_i, imem_rdata_i,
        output stall_i, redirect_i, redirect_pc_i
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues one request at a time to instruction
// memory, fills the IF/ID register, and parks one extra word in a skid
// buffer when decode stalls while a response is landing.
//
// state | meaning
// ------+-----------------------------------------------------------------
// BOOT  | first cycle after reset release, no request
// FETCH | request at pc_q outstanding (imem_req_o=1)
// HOLD  | skid buffer full, waiting for decode to drain the IF/ID register
// DROP  | redirect hit an in-flight request; swallow its stale response
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    fetch_unit_if.master bus
);
    typedef enum logic [1:0] {BOOT, FETCH, HOLD, DROP} state_t;

    // Word alignment is forced by masking rather than slicing so every bit
    // of the source is consumed.
    localparam logic [31:0] BOOT_PC = RESET_PC & ~32'h3;

    state_t      state;
    logic [31:0] pc_q;
    logic        req_q;
    logic        out_valid_q;
    logic [31:0] out_instr_q;
    logic [31:0] out_pc_q;
    logic        skid_valid_q;
    logic [31:0] skid_instr_q;
    logic [31:0] skid_pc_q;
    logic [31:0] redirect_target;
    logic        out_free;

    assign redirect_target = bus.redirect_pc_i & ~32'h3;
    assign out_free        = !out_valid_q || !bus.stall_i;

    assign bus.imem_req_o  = req_q;
    assign bus.imem_addr_o = pc_q;
    assign bus.if_valid_o  = out_valid_q;
    assign bus.if_instr_o  = out_instr_q;
    assign bus.if_pc_o     = out_pc_q;
    assign bus.if_opcode_o = out_instr_q[6:0];

    // Fetch FSM, PC, IF/ID register and skid buffer; redirect overrides all.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state        <= BOOT;
            pc_q         <= BOOT_PC;
            req_q        <= 1'b0;
            out_valid_q  <= 1'b0;
            out_instr_q  <= 32'h0;
            out_pc_q     <= 32'h0;
            skid_valid_q <= 1'b0;
            skid_instr_q <= 32'h0;
            skid_pc_q    <= 32'h0;
        end else if (bus.redirect_i) begin
            pc_q         <= redirect_target;
            out_valid_q  <= 1'b0;
            out_instr_q  <= 32'h0;
            out_pc_q     <= 32'h0;
            skid_valid_q <= 1'b0;
            skid_instr_q <= 32'h0;
            skid_pc_q    <= 32'h0;
            // An unanswered request must have its response swallowed later;
            // an answered one is simply dropped and the target fetched now.
            if ((state == FETCH && !bus.imem_valid_i) || state == DROP) begin
                state <= DROP;
                req_q <= 1'b0;
            end else begin
                state <= FETCH;
                req_q <= 1'b1;
            end
        end else begin
            case (state)
                BOOT: begin
                    state <= FETCH;
                    req_q <= 1'b1;
                    if (!bus.stall_i) begin
                        out_valid_q <= 1'b0;
                        out_instr_q <= 32'h0;
                        out_pc_q    <= 32'h0;
                    end
                end
                FETCH: begin
                    if (bus.imem_valid_i) begin
                        pc_q <= pc_q + 32'd4;
                        if (out_free) begin
                            out_valid_q <= 1'b1;
                            out_instr_q <= bus.imem_rdata_i;
                            out_pc_q    <= pc_q;
                        end else begin
                            skid_valid_q <= 1'b1;
                            skid_instr_q <= bus.imem_rdata_i;
                            skid_pc_q    <= pc_q;
                            state        <= HOLD;
                            req_q        <= 1'b0;
                        end
                    end else if (!bus.stall_i) begin
                        out_valid_q <= 1'b0;
                        out_instr_q <= 32'h0;
                        out_pc_q    <= 32'h0;
                    end
                end
                HOLD: begin
                    if (!bus.stall_i) begin
                        out_valid_q  <= skid_valid_q;
                        out_instr_q  <= skid_instr_q;
                        out_pc_q     <= skid_pc_q;
                        skid_valid_q <= 1'b0;
                        skid_instr_q <= 32'h0;
                        skid_pc_q    <= 32'h0;
                        state        <= FETCH;
                        req_q        <= 1'b1;
                    end
                end
                DROP: begin
                    if (bus.imem_valid_i) begin
                        state <= FETCH;
                        req_q <= 1'b1;
                    end
                    if (!bus.stall_i) begin
                        out_valid_q <= 1'b0;
                        out_instr_q <= 32'h0;
                        out_pc_q    <= 32'h0;
                    end
                end
                default: begin
                    state <= BOOT;
                    req_q <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: memory responses, stalls, redirects,
// asynchronous reset and PC wrap, each with hand-computed expectations.
module tb_fetch_unit;
    logic clk_i;
    logic rst_n_i;
    int   checks;
    int   failures;

    fetch_unit_if bus ();

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .bus     (bus)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_req(input string tag, input logic req, input logic [31:0] addr);
        chk({tag, ".req"},  32'(bus.imem_req_o),  32'(req));
        chk({tag, ".addr"}, bus.imem_addr_o,      addr);
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [31:0] instr, input logic [31:0] pc);
        chk({tag, ".valid"},  32'(bus.if_valid_o),  32'(v));
        chk({tag, ".instr"},  bus.if_instr_o,       instr);
        chk({tag, ".pc"},     bus.if_pc_o,          pc);
        chk({tag, ".opcode"}, 32'(bus.if_opcode_o), 32'(instr[6:0]));
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n_i           = 1'b0;
        bus.imem_valid_i  = 1'b0;
        bus.imem_rdata_i  = 32'h0;
        bus.stall_i       = 1'b0;
        bus.redirect_i    = 1'b0;
        bus.redirect_pc_i = 32'h0;

        #3;
        chk_req("reset", 1'b0, 32'h0);
        chk_out("reset", 1'b0, 32'h0, 32'h0);

        // Release reset; BOOT must ignore a response strobe.
        tick();
        rst_n_i          = 1'b1;
        bus.imem_valid_i = 1'b1;
        bus.imem_rdata_i = 32'hDEAD_BEEF;
        chk_req("boot", 1'b0, 32'h0);
        tick();
        bus.imem_valid_i = 1'b0;
        chk_req("fetch0", 1'b1, 32'h0);
        chk_out("boot_ignore", 1'b0, 32'h0, 32'h0);

        // Sequential fetch 0,4,8 with one-cycle memory latency.
        tick();
        bus.imem_valid_i = 1'b1;
        bus.imem_rdata_i = 32'h0010_0093;
        chk_req("wait0", 1'b1, 32'h0);
        tick();
        bus.imem_valid_i = 1'b0;
        chk_out("seqA", 1'b1, 32'h0010_0093, 32'h0);
        chk_req("fetch4", 1'b1, 32'h4);
        tick();
        bus.imem_valid_i = 1'b1;
        bus.imem_rdata_i = 32'h0020_8133;
        chk_out("bubble1", 1'b0, 32'h0, 32'h0);
        tick();
        bus.imem_valid_i = 1'b0;
        chk_out("seqB", 1'b1, 32'h0020_8133, 32'h4);
        chk_req("fetch8", 1'b1, 32'h8);
        tick();
        bus.imem_valid_i = 1'b1;
        bus.imem_rdata_i = 32'h0000_0517;
        tick();
        bus.imem_valid_i = 1'b0;
        chk_out("seqC", 1'b1, 32'h0000_0517, 32'h8);
        chk_req("fetchC", 1'b1, 32'hC);

        // Stall with a response landing -> skid buffer and HOLD.
        bus.stall_i = 1'b1;
        tick();
        chk_out("stall_hold", 1'b1, 32'h0000_0517, 32'h8);
        bus.imem_valid_i = 1'b1;
        bus.imem_rdata_i = 32'h0000_0063;
        tick();
        bus.imem_valid_i = 1'b1;
        bus.imem_rdata_i = 32'h1111_1111;
        chk_req("hold", 1'b0, 32'h10);
        chk_out("hold_keepC", 1'b1, 32'h0000_0517, 32'h8);
        tick();
        bus.imem_valid_i = 1'b0;
        bus.stall_i      = 1'b0;
        chk_req("hold_ignore", 1'b0, 32'h10);
        chk_out("hold_ignore", 1'b1, 32'h0000_0517, 32'h8);
        tick();
        chk_out("skid_drain", 1'b1, 32'h0000_0063, 32'hC);
        chk_req("after_hold", 1'b1, 32'h10);

        // Redirect with request pending -> DROP, stale response swallowed.
        bus.redirect_i    = 1'b1;
        bus.redirect_pc_i = 32'h0000_0103;
        tick();
        bus.redirect_i = 1'b0;
        chk_req("drop", 1'b0, 32'h100);
        chk_out("drop", 1'b0, 32'h0, 32'h0);
        tick();
        bus.imem_valid_i = 1'b1;
        bus.imem_rdata_i = 32'hBAD0_0013;
        chk_req("drop_wait", 1'b0, 32'h100);
        tick();
        bus.imem_valid_i = 1'b0;
        chk_req("after_drop", 1'b1, 32'h100);
        chk_out("stale_gone", 1'b0, 32'h0, 32'h0);

        // Load one word, then redirect colliding with response and stall.
        tick();
        bus.imem_valid_i = 1'b1;
        bus.imem_rdata_i = 32'h00C0_006F;
        tick();
        bus.imem_valid_i = 1'b0;
        chk_out("loadF", 1'b1, 32'h00C0_006F, 32'h100);
        chk_req("fetch104", 1'b1, 32'h104);
        bus.stall_i       = 1'b1;
        bus.imem_valid_i  = 1'b1;
        bus.imem_rdata_i  = 32'h2222_2233;
        bus.redirect_i    = 1'b1;
        bus.redirect_pc_i = 32'h0000_0200;
        tick();
        bus.stall_i      = 1'b0;
        bus.imem_valid_i = 1'b0;
        bus.redirect_i   = 1'b0;
        chk_out("redir_collide", 1'b0, 32'h0, 32'h0);
        chk_req("redir_collide", 1'b1, 32'h200);

        // Enter DROP, redirect again inside DROP, then async reset mid-cycle.
        bus.redirect_i    = 1'b1;
        bus.redirect_pc_i = 32'h0000_0300;
        tick();
        bus.redirect_pc_i = 32'h0000_0404;
        tick();
        bus.redirect_i = 1'b0;
        chk_req("drop_redir", 1'b0, 32'h404);
        #2;
        rst_n_i = 1'b0;
        #1;
        chk_req("async_rst", 1'b0, 32'h0);
        chk_out("async_rst", 1'b0, 32'h0, 32'h0);
        tick();
        rst_n_i          = 1'b1;
        bus.imem_valid_i = 1'b1;
        bus.imem_rdata_i = 32'h3333_3333;
        chk_req("boot2", 1'b0, 32'h0);
        tick();
        bus.imem_valid_i = 1'b0;
        chk_req("fetch_reset_pc", 1'b1, 32'h0);
        chk_out("boot2_ignore", 1'b0, 32'h0, 32'h0);

        // Redirect to the top word and watch the PC wrap.
        bus.imem_valid_i  = 1'b1;
        bus.imem_rdata_i  = 32'h4444_4444;
        bus.redirect_i    = 1'b1;
        bus.redirect_pc_i = 32'hFFFF_FFFE;
        tick();
        bus.imem_valid_i = 1'b0;
        bus.redirect_i   = 1'b0;
        chk_req("redir_top", 1'b1, 32'hFFFF_FFFC);
        tick();
        bus.imem_valid_i = 1'b1;
        bus.imem_rdata_i = 32'h0000_0037;
        tick();
        bus.imem_valid_i = 1'b0;
        chk_out("top_word", 1'b1, 32'h0000_0037, 32'hFFFF_FFFC);
        chk_req("wrap", 1'b1, 32'h0);
        tick();
        bus.imem_valid_i = 1'b1;
        bus.imem_rdata_i = 32'h0000_0073;
        chk_out("wrap_bubble", 1'b0, 32'h0, 32'h0);
        tick();
        bus.imem_valid_i = 1'b0;
        chk_out("wrapped", 1'b1, 32'h0000_0073, 32'h0);
        chk_req("after_wrap", 1'b1, 32'h4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
